// File: rtl/ft_packet_deframer_if.sv
`default_nettype none
// ============================================================================
// Module   : ft_packet_deframer_if
// Brief    : FT receive-FIFO word stream and reassembled-packet bundle
// Revision : 1.0
// ============================================================================
interface ft_packet_deframer_if;
    logic [15:0] din;
    logic [1:0]  din_be;
    logic        din_empty;
    logic        dout_get;
    logic [87:0] packet_data;
    logic        packet_valid;
    logic [15:0] packet_cnt;

    // master: the deframer itself; slave: the FIFO/packet-sink environment
    modport master (
        input  din, din_be, din_empty,
        output dout_get, packet_data, packet_valid, packet_cnt
    );
    modport slave (
        output din, din_be, din_empty,
        input  dout_get, packet_data, packet_valid, packet_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ft_packet_deframer.sv
`default_nettype none
// ============================================================================
// Module   : ft_packet_deframer
// Brief    : Locks onto 8-word FT frames (marker/magic) and emits 88-bit packets
// Revision : 1.0
// ============================================================================
module ft_packet_deframer #(
    parameter logic [15:0] MAGIC  = 16'hDEC0,
    parameter logic [7:0]  MARKER = 8'h7C
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    ft_packet_deframer_if.master    bus,
    input  wire logic               clear_counters,
    output logic                    locked,
    output logic [31:0]             good_packets,
    output logic [15:0]             frame_errors,
    output logic [15:0]             seq_errors
);

    localparam logic [0:0] C_HUNT = 1'b0;
    localparam logic [0:0] C_LOCK = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [3:0]  r_fill;
    logic [2:0]  r_idx;
    // W0..W6 of the current frame: shifted in while hunting, indexed while locked
    logic [15:0] r_hist [0:6];
    logic [15:0] r_last_cnt;
    logic [87:0] r_packet_data;
    logic [15:0] r_packet_cnt;
    logic        r_packet_valid;
    logic [31:0] r_good;
    logic [15:0] r_ferr;
    logic [15:0] r_serr;

    logic        w_consume;
    logic        w_be_ok;
    logic        w_hunt_match;
    logic        w_lock_check;
    logic        w_last_word;
    logic        w_emit;
    logic        w_seq_check;
    logic        w_seq_err;
    logic        w_frame_err;
    logic        w_shift;
    logic        w_store;

    assign w_consume    = rst_n & ~bus.din_empty;
    assign w_be_ok      = (bus.din_be == 2'b11);
    assign w_hunt_match = (r_fill >= 4'd7) && (r_hist[6] == MAGIC)
                          && (r_hist[5][15:8] == MARKER);
    assign w_lock_check = (r_hist[5][15:8] == MARKER) && (r_hist[6] == MAGIC);
    assign w_last_word  = (r_idx == 3'd7);
    assign w_seq_err    = w_seq_check && (bus.din != (r_last_cnt + 16'd1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_consume) begin
            if (!w_be_ok) begin
                w_state_next = C_HUNT;
            end else begin
                case (r_state)
                    C_HUNT:  if (w_hunt_match) w_state_next = C_LOCK;
                    C_LOCK:  if (w_last_word && !w_lock_check) w_state_next = C_HUNT;
                    default: w_state_next = C_HUNT;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: per-consume actions
    // ------------------------------------------------------------------
    always_comb begin
        w_emit      = 1'b0;
        w_seq_check = 1'b0;
        w_frame_err = 1'b0;
        w_shift     = 1'b0;
        w_store     = 1'b0;
        if (w_consume) begin
            if (!w_be_ok) begin
                w_frame_err = 1'b1;
            end else begin
                case (r_state)
                    C_HUNT: begin
                        w_shift = 1'b1;
                        w_emit  = w_hunt_match;
                    end
                    C_LOCK: begin
                        if (!w_last_word) begin
                            w_store = 1'b1;
                        end else if (w_lock_check) begin
                            w_emit      = 1'b1;
                            w_seq_check = 1'b1;
                        end else begin
                            w_frame_err = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Word history, fill counter and word index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= 4'd0;
            r_idx  <= 3'd0;
            for (int i = 0; i < 7; i++) begin
                r_hist[i] <= 16'd0;
            end
        end else if (w_consume) begin
            // Every entry into HUNT is signalled by a frame error
            if (w_frame_err) begin
                r_fill <= 4'd0;
            end else if (w_shift && (r_fill != 4'd8)) begin
                r_fill <= r_fill + 4'd1;
            end

            if ((r_state == C_HUNT) || w_frame_err) begin
                r_idx <= 3'd0;
            end else begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_shift) begin
                for (int i = 0; i < 6; i++) begin
                    r_hist[i] <= r_hist[i+1];
                end
                r_hist[6] <= bus.din;
            end else if (w_store) begin
                for (int i = 0; i < 7; i++) begin
                    if (r_idx == 3'(i)) r_hist[i] <= bus.din;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_packet_valid <= 1'b0;
            r_packet_data  <= 88'd0;
            r_packet_cnt   <= 16'd0;
            r_last_cnt     <= 16'd0;
        end else begin
            r_packet_valid <= w_emit;
            if (w_emit) begin
                r_packet_data <= {r_hist[5][7:0], r_hist[4], r_hist[3],
                                  r_hist[2], r_hist[1], r_hist[0]};
                r_packet_cnt  <= bus.din;
                r_last_cnt    <= bus.din;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status counters: clear has priority over any increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good <= 32'd0;
            r_ferr <= 16'd0;
            r_serr <= 16'd0;
        end else if (clear_counters) begin
            r_good <= 32'd0;
            r_ferr <= 16'd0;
            r_serr <= 16'd0;
        end else begin
            if (w_emit) r_good <= r_good + 32'd1;
            if (w_frame_err && (r_ferr != 16'hFFFF)) r_ferr <= r_ferr + 16'd1;
            if (w_seq_err && (r_serr != 16'hFFFF)) r_serr <= r_serr + 16'd1;
        end
    end

    assign bus.dout_get     = w_consume;
    assign bus.packet_valid = r_packet_valid;
    assign bus.packet_data  = r_packet_data;
    assign bus.packet_cnt   = r_packet_cnt;
    assign locked           = (r_state == C_LOCK);
    assign good_packets     = r_good;
    assign frame_errors     = r_ferr;
    assign seq_errors       = r_serr;

endmodule
`default_nettype wire

// File: doc/ft_packet_deframer.md
FT_PACKET_DEFRAMER -- requirements
Module: ft_packet_deframer

Interface
REQ-001 The block SHALL have parameter MAGIC, default 16'hDEC0, the frame word 6 magic value.
REQ-002 The block SHALL have parameter MARKER, default 8'h7C, the frame word 5 upper-byte marker.
REQ-003 The block SHALL have a port clk, input, width 1: single clock for all logic.
REQ-004 The block SHALL have a port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have a port din, input, width 16: word from the FT receive FIFO, valid while din_empty=0 (first-word-fall-through).
REQ-006 The block SHALL have a port din_be, input, width 2: byte enables of din.
REQ-007 The block SHALL have a port din_empty, input, width 1: receive FIFO empty.
REQ-008 The block SHALL have a port dout_get, output, width 1: pops din; a word is consumed on any cycle with dout_get=1 and din_empty=0.
REQ-009 The block SHALL have a port clear_counters, input, width 1: synchronous clear of the status counters.
REQ-010 The block SHALL have a port packet_data, output, width 88: reassembled payload.
REQ-011 The block SHALL have a port packet_valid, output, width 1: one-cycle strobe that qualifies packet_data and packet_cnt.
REQ-012 The block SHALL have a port packet_cnt, output, width 16: sequence word (frame word 7) of the emitted packet.
REQ-013 The block SHALL have a port locked, output, width 1: high while in LOCK.
REQ-014 The block SHALL have a port good_packets, output, width 32: count of emitted packets, wrapping.
REQ-015 The block SHALL have a port frame_errors, output, width 16: count of frame errors, saturating.
REQ-016 The block SHALL have a port seq_errors, output, width 16: count of sequence errors, saturating.

Function
REQ-017 The frame format SHALL be 8 words: W0..W4 = data[15:0]..data[79:64]; W5 = {MARKER, data[87:80]}; W6 = MAGIC; W7 = sequence count.
REQ-018 dout_get SHALL equal !din_empty while rst_n=1, and 0 while rst_n=0; the block never back-pressures.
REQ-019 The state machine SHALL have two states, HUNT and LOCK; it SHALL enter HUNT on reset.
REQ-020 In HUNT, each consumed word SHALL shift into an 8-word history window, and a fill counter (0..8, saturating) SHALL count words consumed since entering HUNT.
REQ-021 In HUNT, a match SHALL occur when the fill count is at least 8 (including the word just consumed), the word before the newest equals MAGIC, and the word two before the newest has upper byte MARKER.
REQ-022 On a match, the block SHALL emit the windowed packet, with the newest word as the sequence count, skip the sequence check, and go to LOCK with word index 0.
REQ-023 In LOCK, consumed words SHALL be stored by word index 0..7, and the index SHALL advance by 1 per consumed word.
REQ-024 In LOCK, when W7 is consumed and stored W5[15:8]=MARKER and W6=MAGIC, the block SHALL emit the packet, and the index SHALL wrap to 0.
REQ-025 In LOCK, when W7 is consumed and the marker or magic check fails, the block SHALL not emit, SHALL increment frame_errors, and SHALL enter HUNT with the fill counter at 0.
REQ-026 A consumed word with din_be != 2'b11 SHALL increment frame_errors in either state, SHALL not be stored, and SHALL cause entry to HUNT with the fill counter at 0.
REQ-027 Emit SHALL mean: packet_data, packet_cnt and packet_valid=1 are registered in the cycle after the W7 consume (latency 1); packet_data and packet_cnt hold until the next emit, and packet_valid is high for one cycle only.
REQ-028 Sequence check (LOCK emits only): if W7 != last_cnt+1 (mod 2^16), the block SHALL increment seq_errors but still emit the packet; last_cnt SHALL update on every emit, including 16'hFFFF followed by 16'h0000 with no error.
REQ-029 good_packets SHALL increment on every emit.
REQ-030 When clear_counters=1, the three counters SHALL go to 0 on the next edge; clear SHALL win over a simultaneous increment.
REQ-031 Idle 16'hBCBC words SHALL receive no special treatment; they are consumed as ordinary words.

Reset
REQ-032 When rst_n=0, asynchronously: state=HUNT, fill=0, index=0, packet_valid=0, packet_data=0, packet_cnt=0, last_cnt=0, locked=0, all counters=0, dout_get=0.
REQ-033 Reset asserted mid-frame SHALL discard partial words; after release, the block SHALL hunt afresh.

Verification
REQ-034 Stream frames with data=88'h0102..0B and counts 5,6,7 back-to-back -> three packet_valid pulses, packet_cnt 5,6,7, each pulse 1 cycle after W7, good_packets=3, seq_errors=0.
REQ-035 Prefix 3 junk words before valid frames -> first emit at the first full frame, locked=1 after it, frame_errors=0.
REQ-036 In LOCK, corrupt W6 to 16'hDEC1 -> no emit, frame_errors=1, locked=0, re-lock on the next good frame.
REQ-037 Counts 16'hFFFF then 16'h0000, then skip to 16'h0005 -> seq_errors=1, all three packets emitted.
REQ-038 din_be=2'b01 on W2 -> frame_errors increments and the block returns to HUNT; with din_empty toggling randomly between words -> results identical to the gap-free case.
REQ-039 clear_counters asserted on the same cycle as an emit -> counters read 0 afterward; rst_n pulsed low mid-frame -> all outputs at reset values immediately.
